// File: rtl/scoreboard_pkg.sv
// Shared types and glyph data for the scoreboard display pipeline.
package scoreboard_pkg;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_state_e;

  localparam int FONT_W = 3;
  localparam int FONT_H = 5;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // One 15-bit word per digit, top row in the MSBs, leftmost pixel first.
  localparam logic [FONT_W*FONT_H-1:0] FONT [10] = '{
    15'b111_101_101_101_111,
    15'b010_110_010_010_111,
    15'b111_001_111_100_111,
    15'b111_001_111_001_111,
    15'b101_101_111_001_001,
    15'b111_100_111_001_111,
    15'b111_100_111_101_111,
    15'b111_001_001_001_001,
    15'b111_101_111_101_111,
    15'b111_101_111_001_111
  };

endpackage

// File: rtl/pixel_scan_gen_if.sv
// 1-bit raster pixel stream with position and framing strobes.
interface pixel_scan_gen_if #(
  parameter int XW = 5,
  parameter int YW = 4
);
  logic          pixel_out;
  logic          pixel_valid;
  logic          line_end;
  logic          frame_start;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;

  modport master (output pixel_out, pixel_valid, line_end, frame_start, x_pos, y_pos);
  modport slave  (input  pixel_out, pixel_valid, line_end, frame_start, x_pos, y_pos);
endinterface

// File: rtl/digit_font_rom.sv
// 3x5 digit glyph row lookup; codes 10..15 and rows past the glyph read as blank.
module digit_font_rom
  import scoreboard_pkg::*;
(
  input  logic [3:0]        digit,
  input  logic [2:0]        row,
  output logic [FONT_W-1:0] bits
);

  always_comb begin
    bits = '0;
    if (digit < 4'd10 && row < 3'(FONT_H))
      bits = FONT[digit][(FONT_H - 1 - int'(row)) * FONT_W +: FONT_W];
  end

endmodule

// File: rtl/pixel_scan_gen.sv
// Raster-scan source rendering two score digits; one registered pixel per clock.
module pixel_scan_gen
  import scoreboard_pkg::*;
#(
  parameter int H_ACTIVE = 16,
  parameter int H_BLANK  = 4,
  parameter int V_ACTIVE = 8,
  parameter int V_BLANK  = 2,
  parameter int DA_X     = 2,
  parameter int DB_X     = 10,
  parameter int D_Y      = 1
) (
  input  logic             clk_u,
  input  logic             rst_u,
  input  logic             en_i,
  input  logic [3:0]       score_a_i,
  input  logic [3:0]       score_b_i,
  output logic             busy,
  pixel_scan_gen_if.master ps
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [XW-1:0] X_LE   = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] A_LO   = XW'(DA_X);
  localparam logic [XW-1:0] A_HI   = XW'(DA_X + FONT_W - 1);
  localparam logic [XW-1:0] B_LO   = XW'(DB_X);
  localparam logic [XW-1:0] B_HI   = XW'(DB_X + FONT_W - 1);
  localparam logic [YW-1:0] G_LO   = YW'(D_Y);
  localparam logic [YW-1:0] G_HI   = YW'(D_Y + FONT_H - 1);

  if (!(DB_X + 2 < H_ACTIVE && D_Y + 4 < V_ACTIVE)) begin : g_bad_glyph_window
    $error("glyph windows must lie inside the active area");
  end

  scan_state_e   state, nxt_state;
  logic [XW-1:0] x_q, nx;
  logic [YW-1:0] y_q, ny;
  logic [3:0]    sa_q, sb_q, nsa, nsb;

  // Next position and latched scores; outputs are then registered from these
  // so every strobe describes the same pixel as x_pos/y_pos.
  always_comb begin
    nxt_state = state;
    nx        = x_q;
    ny        = y_q;
    nsa       = sa_q;
    nsb       = sb_q;
    case (state)
      IDLE: if (en_i) begin
        nxt_state = SCAN;
        nx        = '0;
        ny        = '0;
        nsa       = score_a_i;
        nsb       = score_b_i;
      end
      SCAN: begin
        if (x_q == X_LAST) begin
          nx = '0;
          if (y_q == Y_LAST) begin
            ny = '0;
            if (en_i) begin
              nsa = score_a_i;
              nsb = score_b_i;
            end else begin
              nxt_state = IDLE;
            end
          end else begin
            ny = y_q + YW'(1);
          end
        end else begin
          nx = x_q + XW'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  logic              scan_n, vld_n, a_hit, b_hit, pix_n;
  logic [2:0]        row;
  logic [1:0]        col_a, col_b;
  logic [FONT_W-1:0] bits_a, bits_b;

  assign scan_n = (nxt_state == SCAN);
  assign vld_n  = scan_n && (nx < X_ACT) && (ny < Y_ACT);
  assign a_hit  = (nx >= A_LO) && (nx <= A_HI) && (ny >= G_LO) && (ny <= G_HI);
  assign b_hit  = (nx >= B_LO) && (nx <= B_HI) && (ny >= G_LO) && (ny <= G_HI);
  assign row    = 3'(ny - G_LO);
  assign col_a  = 2'(nx - A_LO);
  assign col_b  = 2'(nx - B_LO);
  assign pix_n  = vld_n && ((a_hit && bits_a[2'd2 - col_a]) || (b_hit && bits_b[2'd2 - col_b]));

  digit_font_rom u_rom_a (.digit(nsa), .row(row), .bits(bits_a));
  digit_font_rom u_rom_b (.digit(nsb), .row(row), .bits(bits_b));

  always_ff @(posedge clk_u or posedge rst_u) begin
    if (rst_u) begin
      state          <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      sa_q           <= BLANK_CODE;
      sb_q           <= BLANK_CODE;
      busy           <= 1'b0;
      ps.pixel_out   <= 1'b0;
      ps.pixel_valid <= 1'b0;
      ps.line_end    <= 1'b0;
      ps.frame_start <= 1'b0;
    end else begin
      state          <= nxt_state;
      x_q            <= scan_n ? nx : '0;
      y_q            <= scan_n ? ny : '0;
      sa_q           <= nsa;
      sb_q           <= nsb;
      busy           <= scan_n;
      ps.pixel_out   <= pix_n;
      ps.pixel_valid <= vld_n;
      ps.line_end    <= vld_n && (nx == X_LE);
      ps.frame_start <= scan_n && (nx == '0) && (ny == '0);
    end
  end

  assign ps.x_pos = x_q;
  assign ps.y_pos = y_q;

endmodule

// File: doc/pixel_scan_gen.md
Name: pixel_scan_gen

Overview:
- Raster-scan pixel source for the scoreboard display: renders two score digits (3x5 font) on a small bitmap and emits one pixel bit per clock.
- Transmitter side of the 1-bit pixel stream. Its pixel_out drives the downstream pixel-to-colour output stage, which maps 1 to white and 0 to black.
- Generates position and framing strobes so downstream stages and the bench can align.

Parameters:
- H_ACTIVE, 16, visible columns per line
- H_BLANK, 4, blank cycles after each line
- V_ACTIVE, 8, visible lines per frame
- V_BLANK, 2, blank lines after each frame
- DA_X, 2, left column of digit A glyph
- DB_X, 10, left column of digit B glyph
- D_Y, 1, top row of both glyphs

Ports:
- clk_u  in  1  clock
- rst_u  in  1  reset; asynchronous, active-high
- en_i  in  1  scan enable, level
- score_a_i  in  4  digit A value, 0..9; values 10..15 render blank
- score_b_i  in  4  digit B value, 0..9; values 10..15 render blank
- pixel_out  out  1  pixel bit (1 = lit)
- pixel_valid  out  1  pixel_out lies in the active area
- line_end  out  1  pulse on the last active pixel of each active line
- frame_start  out  1  pulse on pixel (0,0) of each frame
- x_pos  out  $clog2(H_ACTIVE+H_BLANK)  current column
- y_pos  out  $clog2(V_ACTIVE+V_BLANK)  current line
- busy  out  1  high while a frame is in progress

Behaviour:
- H_TOTAL = H_ACTIVE + H_BLANK; V_TOTAL = V_ACTIVE + V_BLANK. One frame is H_TOTAL*V_TOTAL cycles (200 at defaults).
- FSM states: IDLE, SCAN.
- Reset values: state IDLE; all outputs 0; latched scores 4'hF (blank).
- All outputs are registered. pixel_out, pixel_valid, line_end, frame_start, x_pos and y_pos describe the same pixel in the same cycle.
- IDLE: counters held at 0 and all outputs 0.
  - If en_i = 1 at a clock edge, the next cycle is in SCAN with x_pos = y_pos = 0 and frame_start = 1.
  - Scores are sampled at that same edge.
- SCAN counting: x increments each cycle and wraps at H_TOTAL-1; y increments on x wrap.
- End of frame, at x = H_TOTAL-1 and y = V_TOTAL-1:
  - en_i = 1: wrap to (0,0), pulse frame_start, re-sample both scores.
  - en_i = 0: return to IDLE.
  - en_i dropping mid-frame has no effect until the frame ends; frames are never truncated except by reset.
- Scores are sampled only at frame start, so a score change mid-frame is not visible before the next frame (no tearing).
- pixel_valid = (x < H_ACTIVE) && (y < V_ACTIVE).
- line_end = pixel_valid && (x == H_ACTIVE-1).
- pixel_out = 0 whenever pixel_valid = 0.
- Glyph lookup, digit A: if DA_X <= x <= DA_X+2 and D_Y <= y <= D_Y+4, then col = x-DA_X, row = y-D_Y, and pixel_out = font(score_a_latched)[row][2-col]. Digit B is identical using DB_X and score_b_latched. All other active pixels are 0.
- Font rows are 3-bit, MSB = leftmost pixel:
  - 0: 111,101,101,101,111
  - 1: 010,110,010,010,111
  - 2: 111,001,111,100,111
  - 3: 111,001,111,001,111
  - 4: 101,101,111,001,001
  - 5: 111,100,111,001,111
  - 6: 111,100,111,101,111
  - 7: 111,001,001,001,001
  - 8: 111,101,111,101,111
  - 9: 111,101,111,001,111
  - 10..15: 000 in all rows.
- busy = (state == SCAN).
- rst_u asserted mid-frame: all outputs go to 0 immediately (asynchronous) and the FSM enters IDLE. After release, a new frame starts only from (0,0), and only once en_i = 1 is sampled.
- Elaboration constraint: glyph windows must fit inside the active area, i.e. DB_X+2 < H_ACTIVE and D_Y+4 < V_ACTIVE.

Decomposition:
- Shared package scoreboard_pkg holds:
  - state encoding IDLE/SCAN
  - FONT_W = 3, FONT_H = 5
  - the 10-entry font table as constants
  - BLANK_CODE = 4'hF
- One sub-module, digit_font_rom: purely combinational; inputs digit[3:0] and row[2:0], output bits[2:0]. Instantiated twice, once per digit.

Test Plan:
- Frame timing: en_i = 1 held, scores 0/0 → frame_start pulses exactly every 200 cycles; line_end occurs 8 times per frame at x = 15; pixel_valid is high for 128 cycles per frame.
- Glyph content: score_a = 1, score_b = 8 → 8 lit pixels in digit A window and 13 in digit B window. Spot checks (x=3,y=1)=1, (x=2,y=1)=0, (x=11,y=2)=0, (x=11,y=3)=1.
- Blank code: score_a = 12, score_b = 15 → zero lit pixels over a full frame.
- Mid-frame update: scores 3/3 at frame start, switched to 7/7 at y = 4 → current frame shows 3/3 entirely; the next frame shows 7/7.
- Enable drop: en_i falls at y = 2 → the frame runs to (19,9); busy falls the next cycle, after which outputs stay 0 and no further frame_start occurs.
- Reset mid-frame: pulse rst_u at (5,3) → all outputs 0 at once; after release with en_i = 1, frame_start occurs one cycle after the first sampling edge, starting at (0,0).
